uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 29 ++
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host/transmitter-side signal bundle for uart_tx_fifo.
// master: the host and transmitter side; slave: the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              flush;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] tx_data;
  logic              tx_send;
  logic              tx_data_ready;
  logic              overflow;

  modport master (
    output wr_data, wr_en, flush, tx_data_ready,
    input  full, empty, count, tx_data, tx_send, overflow
  );

  modport slave (
    input  wr_data, wr_en, flush, tx_data_ready,
    output full, empty, count, tx_data, tx_send, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a send/ready handshake.
// Optional feature macro: UART_TX_FIFO_OVF_EN -- sticky overflow flag on
// dropped pushes; when undefined, overflow is tied low and has no register.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    BUSY     = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              full_q;
  logic              empty_q;
  logic              tx_send_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              push_c;
  logic              pop_c;

  assign push_c = bus.wr_en & ~full_q;

  // Drain FSM: pop one byte per send/ready handshake.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && bus.tx_data_ready) begin
          pop_c   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: if (!bus.tx_data_ready) state_d = BUSY;
      BUSY:     if (bus.tx_data_ready)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Occupancy after this cycle; flush wins over a same-cycle push.
  always_comb begin
    count_d = count_q;
    if (bus.flush) count_d = '0;
    else           count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Pointers, count and the full/empty flags kept in lockstep with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage array; needs no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_c && !bus.flush) mem[wr_ptr_q] <= bus.wr_data;
  end

  // Send strobe and held byte toward the transmitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_send_q <= pop_c;
      if (pop_c) tx_data_q <= mem[rd_ptr_q];
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic overflow_q;

  // Sticky drop flag, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overflow_q <= 1'b0;
    else if (bus.flush)              overflow_q <= 1'b0;
    else if (bus.wr_en && full_q)    overflow_q <= 1'b1;
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.full    = full_q;
  assign bus.empty   = empty_q;
  assign bus.count   = count_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_send = tx_send_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queue-based reference model predicts
// each send; a monitor checks every strobe and the status outputs.
module tb_uart_tx_fifo;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 8;

`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_sent   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue plus handshake phase
  // (0: may send, 1: sent and awaiting ready low, 2: awaiting ready high).
  logic [7:0] q_m[$];
  logic [7:0] exp_q[$];
  int         phase_m = 0;
  bit         ovf_m = 1'b0;
  logic [7:0] last_tx = 8'h00;
  bit         m_full;
  bit         m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m.delete();
      exp_q.delete();
      phase_m = 0;
      ovf_m   = 1'b0;
    end else begin
      m_full = (q_m.size() == DEPTH);
      m_rdy  = bus.tx_data_ready;
      if (phase_m == 0 && q_m.size() > 0 && m_rdy) begin
        last_tx = q_m.pop_front();
        exp_q.push_back(last_tx);
        phase_m = 1;
      end else if (phase_m == 1 && !m_rdy) begin
        phase_m = 2;
      end else if (phase_m == 2 && m_rdy) begin
        phase_m = 0;
      end
      if (bus.flush) begin
        q_m.delete();
        ovf_m = 1'b0;
      end else if (bus.wr_en) begin
        if (!m_full) q_m.push_back(bus.wr_data);
        else if (OVF_ON) ovf_m = 1'b1;
      end
    end
  end

  // Transmitter model: drops ready for busy_len cycles after each send.
  int busy_len = 3;
  int busy_cnt = 0;
  bit hold = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_send === 1'b1) busy_cnt = busy_len;
    else if (busy_cnt > 0)    busy_cnt = busy_cnt - 1;
    bus.tx_data_ready = !hold && (busy_cnt == 0);
  end

  // Monitor: compare status every cycle and pop the scoreboard on each send.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 32'(bus.count), 32'(q_m.size()));
      chk("full", 32'(bus.full), 32'(q_m.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(q_m.size() == 0));
      chk("overflow", 32'(bus.overflow), 32'(ovf_m));
      if (bus.tx_send === 1'b1) begin
        n_sent++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_send: tx_send=1 tx_data=0x%0h, expected no send at %0t",
                   bus.tx_data, $time);
        end else begin
          chk("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (phase_m != 0) chk("tx_data_stable", 32'(bus.tx_data), 32'(last_tx));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int i = 0;
    while ((q_m.size() != 0 || exp_q.size() != 0 || phase_m != 0) && i < limit) begin
      step();
      i++;
    end
    chk(name, 32'(i < limit), 32'd1);
  endtask

  function automatic bit pop_next();
    return (phase_m == 0) && (q_m.size() > 0) && (bus.tx_data_ready === 1'b1);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'd0);
    chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
    chk({tag, "_full"}, 32'(bus.full), 32'd0);
    chk({tag, "_tx_send"}, 32'(bus.tx_send), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    int guard;
    int pairs;
    int sent0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.flush   = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // Single byte through an idle transmitter.
    busy_len = 3;
    sent0 = n_sent;
    push(8'h55);
    wait_drain("t1_drain", 50);
    chk("t1_sends", 32'(n_sent - sent0), 32'd1);
    chk("t1_count", 32'(bus.count), 32'd0);

    // Fill to full with the transmitter stalled, then one dropped push.
    hold = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd16);
    push(8'hAA);
    chk("t2_overflow", 32'(bus.overflow), 32'(OVF_ON));
    chk("t2_count_after_drop", 32'(bus.count), 32'd16);

    // Drain the full FIFO through a slow transmitter.
    busy_len = 10;
    hold = 1'b0;
    sent0 = n_sent;
    wait_drain("t3_drain", 600);
    chk("t3_sends", 32'(n_sent - sent0), 32'd16);

    // Count of 5, then 20 push-with-pop pairs across the pointer wrap.
    hold = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 5; i++) push(8'($urandom));
    chk("t4_count5", 32'(bus.count), 32'd5);
    busy_len = 2;
    hold = 1'b0;
    pairs = 0;
    guard = 0;
    while (pairs < 20 && guard < 500) begin
      if (pop_next()) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'($urandom);
        pairs++;
      end else begin
        bus.wr_en = 1'b0;
      end
      step();
      guard++;
    end
    bus.wr_en = 1'b0;
    chk("t4_pairs_done", 32'(pairs), 32'd20);
    chk("t4_count_held", 32'(bus.count), 32'd5);

    // Build to 8, then flush with a same-cycle push while a pop completes.
    hold = 1'b1;
    repeat (3) step();
    guard = 0;
    while (q_m.size() < 8 && guard < 20) begin
      push(8'($urandom));
      guard++;
    end
    chk("t5_count8", 32'(bus.count), 32'd8);
    busy_len = 4;
    hold = 1'b0;
    guard = 0;
    while (!pop_next() && guard < 50) begin
      step();
      guard++;
    end
    chk("t5_pop_seen", 32'(guard < 50), 32'd1);
    sent0 = n_sent;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    bus.flush   = 1'b1;
    step();
    bus.wr_en = 1'b0;
    bus.flush = 1'b0;
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_empty", 32'(bus.empty), 32'd1);
    chk("t5_overflow", 32'(bus.overflow), 32'd0);
    wait_drain("t5_drain", 100);
    chk("t5_inflight_sent", 32'(n_sent - sent0), 32'd1);

    // Randomised traffic with occasional flushes and stalls.
    for (int c = 0; c < 400; c++) begin
      if (c % 40 == 0) begin
        busy_len = int'($urandom_range(1, 6));
        hold = ($urandom % 4 == 0);
      end
      bus.wr_en   = $urandom % 2 == 1;
      bus.wr_data = 8'($urandom);
      bus.flush   = ($urandom % 32 == 0);
      step();
    end
    bus.wr_en = 1'b0;
    bus.flush = 1'b0;
    hold = 1'b0;
    wait_drain("t6_drain", 1000);

    // Reset while the transmitter is busy with three bytes queued.
    busy_len = 30;
    push(8'h11);
    guard = 0;
    while (phase_m != 2 && guard < 20) begin
      step();
      guard++;
    end
    chk("t7_busy_reached", 32'(phase_m), 32'd2);
    for (int i = 0; i < 3; i++) push(8'(8'h20 + i));
    chk("t7_count3", 32'(bus.count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("t7_async");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    busy_len = 3;
    sent0 = n_sent;
    repeat (15) step();
    chk("t7_no_send", 32'(n_sent - sent0), 32'd0);
    push(8'h3C);
    wait_drain("t7_drain", 100);
    chk("t7_new_send", 32'(n_sent - sent0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
